// File: rtl/lc4_issue_ctrl.sv
// Issue/hazard controller for the LC4 decode stage: tracks one in-flight ECC op,
// blocks RAW/WAW and structural conflicts, and inserts bubbles after control ops.
module lc4_issue_ctrl #(
  parameter int MULTI_LAT    = 4,
  parameter int CTRL_BUBBLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic [4:0]  id_r1sel,
  input  logic        id_r1re,
  input  logic [4:0]  id_r2sel,
  input  logic        id_r2re,
  input  logic [4:0]  id_wsel,
  input  logic        id_regfile_we,
  input  logic        id_is_multi,
  input  logic        id_is_control,
  output logic        issue_fire,
  output logic        id_stall,
  output logic        flush,
  output logic        ecc_start,
  output logic        ecc_done,
  output logic [4:0]  ecc_wsel,
  output logic        ecc_we,
  output logic        busy,
  output logic [15:0] issue_cnt,
  output logic [15:0] stall_cnt
);

  // state  | meaning
  // RUN    | normal issue, only hazards can stall
  // BUBBLE | post-control-op window, issue blocked and fetch flushed

  typedef enum logic {RUN, BUBBLE} state_e;

  localparam logic [3:0] LAT = 4'(MULTI_LAT);
  localparam logic [2:0] BUB = 3'(CTRL_BUBBLES);

  state_e      state_q, state_d;
  logic [2:0]  bub_q, bub_d;
  logic [3:0]  ecc_cnt_q, ecc_cnt_d;
  logic [4:0]  ecc_wsel_q, ecc_wsel_d;
  logic        ecc_we_q, ecc_we_d;
  logic        ecc_done_q, ecc_done_d;
  logic [15:0] issue_cnt_q, issue_cnt_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic        raw, structural;

  always_comb begin
    busy       = (ecc_cnt_q != 4'd0);
    raw        = busy & ecc_we_q &
                 ((id_r1re & (id_r1sel == ecc_wsel_q)) |
                  (id_r2re & (id_r2sel == ecc_wsel_q)) |
                  (id_regfile_we & (id_wsel == ecc_wsel_q)));
    structural = busy & id_is_multi;
    flush      = (state_q == BUBBLE);
    id_stall   = id_valid & (flush | raw | structural);
    issue_fire = id_valid & ~id_stall;
    ecc_start  = issue_fire & id_is_multi;
  end

  always_comb begin
    state_d     = state_q;
    bub_d       = bub_q;
    ecc_cnt_d   = ecc_cnt_q;
    ecc_wsel_d  = ecc_wsel_q;
    ecc_we_d    = ecc_we_q;
    ecc_done_d  = 1'b0;
    issue_cnt_d = issue_cnt_q;
    stall_cnt_d = stall_cnt_q;

    // A start can only happen while idle, since a multi op stalls whenever busy.
    if (ecc_start) begin
      ecc_cnt_d  = LAT;
      ecc_wsel_d = id_wsel;
      ecc_we_d   = id_regfile_we;
    end else if (ecc_cnt_q > 4'd1) begin
      ecc_cnt_d = ecc_cnt_q - 4'd1;
    end else if (ecc_cnt_q == 4'd1) begin
      ecc_cnt_d  = 4'd0;
      ecc_done_d = 1'b1;
    end

    case (state_q)
      RUN: begin
        if (issue_fire && id_is_control) begin
          state_d = BUBBLE;
          bub_d   = BUB;
        end
      end
      BUBBLE: begin
        if (bub_q <= 3'd1) begin
          state_d = RUN;
          bub_d   = 3'd0;
        end else begin
          bub_d = bub_q - 3'd1;
        end
      end
      default: begin
        state_d = RUN;
        bub_d   = 3'd0;
      end
    endcase

    if (issue_fire && (issue_cnt_q != 16'hFFFF)) issue_cnt_d = issue_cnt_q + 16'd1;
    if (id_stall && (stall_cnt_q != 16'hFFFF)) stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      bub_q       <= 3'd0;
      ecc_cnt_q   <= 4'd0;
      ecc_wsel_q  <= 5'd0;
      ecc_we_q    <= 1'b0;
      ecc_done_q  <= 1'b0;
      issue_cnt_q <= 16'd0;
      stall_cnt_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      bub_q       <= bub_d;
      ecc_cnt_q   <= ecc_cnt_d;
      ecc_wsel_q  <= ecc_wsel_d;
      ecc_we_q    <= ecc_we_d;
      ecc_done_q  <= ecc_done_d;
      issue_cnt_q <= issue_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign ecc_done  = ecc_done_q;
  assign ecc_wsel  = ecc_wsel_q;
  assign ecc_we    = ecc_we_q;
  assign issue_cnt = issue_cnt_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_lc4_issue_ctrl.sv
// Bench for lc4_issue_ctrl: directed cycle table, randomized run against a
// cycle-timeline model, and a counter saturation run on a long-latency instance.
module tb_lc4_issue_ctrl;

  localparam int ML = 4;
  localparam int CB = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, id_valid, id_r1re, id_r2re, id_regfile_we, id_is_multi, id_is_control;
  logic [4:0]  id_r1sel, id_r2sel, id_wsel;
  logic        issue_fire, id_stall, flush, ecc_start, ecc_done, ecc_we, busy;
  logic [4:0]  ecc_wsel;
  logic [15:0] issue_cnt, stall_cnt;

  logic        s_valid, s_r1re, s_we, s_multi;
  logic [4:0]  s_r1sel, s_wsel;
  logic        s_fire, s_stall, s_flush, s_start, s_done, s_ecc_we, s_busy;
  logic [4:0]  s_ecc_wsel;
  logic [15:0] s_issue_cnt, s_stall_cnt;

  lc4_issue_ctrl #(.MULTI_LAT(ML), .CTRL_BUBBLES(CB)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_r1sel(id_r1sel), .id_r1re(id_r1re), .id_r2sel(id_r2sel), .id_r2re(id_r2re),
    .id_wsel(id_wsel), .id_regfile_we(id_regfile_we),
    .id_is_multi(id_is_multi), .id_is_control(id_is_control),
    .issue_fire(issue_fire), .id_stall(id_stall), .flush(flush),
    .ecc_start(ecc_start), .ecc_done(ecc_done), .ecc_wsel(ecc_wsel), .ecc_we(ecc_we),
    .busy(busy), .issue_cnt(issue_cnt), .stall_cnt(stall_cnt)
  );

  lc4_issue_ctrl #(.MULTI_LAT(15), .CTRL_BUBBLES(7)) u_sat (
    .clk(clk), .rst(rst), .id_valid(s_valid),
    .id_r1sel(s_r1sel), .id_r1re(s_r1re), .id_r2sel(5'd0), .id_r2re(1'b0),
    .id_wsel(s_wsel), .id_regfile_we(s_we),
    .id_is_multi(s_multi), .id_is_control(1'b0),
    .issue_fire(s_fire), .id_stall(s_stall), .flush(s_flush),
    .ecc_start(s_start), .ecc_done(s_done), .ecc_wsel(s_ecc_wsel), .ecc_we(s_ecc_we),
    .busy(s_busy), .issue_cnt(s_issue_cnt), .stall_cnt(s_stall_cnt)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    logic       rst, valid;
    logic [4:0] r1;
    logic       r1re;
    logic [4:0] r2;
    logic       r2re;
    logic [4:0] w;
    logic       we, multi, ctrl;
    logic       fire, stall, flsh, bsy, done;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic rs, v, input logic [4:0] r1, input logic r1e,
                     input logic [4:0] r2, input logic r2e, input logic [4:0] w,
                     input logic we, mu, ct, input logic ef, es, efl, eb, ed);
    vec_t x;
    x.rst = rs; x.valid = v; x.r1 = r1; x.r1re = r1e; x.r2 = r2; x.r2re = r2e;
    x.w = w; x.we = we; x.multi = mu; x.ctrl = ct;
    x.fire = ef; x.stall = es; x.flsh = efl; x.bsy = eb; x.done = ed;
    tbl.push_back(x);
  endtask

  task automatic drive(input logic rs, v, input logic [4:0] r1, input logic r1e,
                       input logic [4:0] r2, input logic r2e, input logic [4:0] w,
                       input logic we, mu, ct);
    rst = rs; id_valid = v; id_r1sel = r1; id_r1re = r1e; id_r2sel = r2; id_r2re = r2e;
    id_wsel = w; id_regfile_we = we; id_is_multi = mu; id_is_control = ct;
  endtask

  // Timeline model: ECC occupancy and bubble windows expressed as absolute cycle numbers.
  longint     t, ecc_end, done_at, bub_end;
  logic [4:0] m_wsel;
  logic       m_we;
  int         m_issue, m_stall;

  task automatic model_reset();
    ecc_end = 0; done_at = -1; bub_end = 0; m_wsel = 5'd0; m_we = 1'b0;
    m_issue = 0; m_stall = 0;
  endtask

  task automatic model_cycle();
    logic mb, mfl, mraw, ms, mf;
    mb   = (t < ecc_end);
    mfl  = (t < bub_end);
    mraw = mb && m_we && ((id_r1re && id_r1sel == m_wsel) || (id_r2re && id_r2sel == m_wsel) ||
                          (id_regfile_we && id_wsel == m_wsel));
    ms   = id_valid && (mfl || mraw || (mb && id_is_multi));
    mf   = id_valid && !ms;
    @(negedge clk);
    chk("rnd_fire", 32'(issue_fire), 32'(mf));
    chk("rnd_stall", 32'(id_stall), 32'(ms));
    chk("rnd_flush", 32'(flush), 32'(mfl));
    chk("rnd_start", 32'(ecc_start), 32'(mf && id_is_multi));
    chk("rnd_busy", 32'(busy), 32'(mb));
    chk("rnd_done", 32'(ecc_done), 32'(t == done_at));
    chk("rnd_wsel", 32'(ecc_wsel), 32'(m_wsel));
    chk("rnd_we", 32'(ecc_we), 32'(m_we));
    chk("rnd_issue_cnt", 32'(issue_cnt), 32'(m_issue));
    chk("rnd_stall_cnt", 32'(stall_cnt), 32'(m_stall));
    if (rst) begin
      model_reset();
    end else begin
      if (mf && id_is_multi) begin
        ecc_end = t + 1 + ML; done_at = ecc_end; m_wsel = id_wsel; m_we = id_regfile_we;
      end
      if (mf && id_is_control) bub_end = t + 1 + CB;
      if (mf && m_issue < 65535) m_issue++;
      if (ms && m_stall < 65535) m_stall++;
    end
    t++;
  endtask

  initial begin
    int s_iss, s_stl, s_end;

    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    s_valid = 0; s_r1sel = 5'd7; s_r1re = 1; s_wsel = 5'd7; s_we = 1; s_multi = 1;

    // rst v r1 r1e r2 r2e w we mu ct | fire stall flush busy done
    add(1,1,0,0,0,0,0,0,0,0, 1,0,0,0,0);
    add(0,1,0,0,0,0,3,1,1,0, 1,0,0,0,0);
    for (int i = 0; i < 4; i++) add(0,1,3,1,0,0,0,0,0,0, 0,1,0,1,0);
    add(0,1,3,1,0,0,0,0,0,0, 1,0,0,0,1);
    add(0,1,0,0,0,0,3,1,1,0, 1,0,0,0,0);
    add(0,1,4,1,0,0,0,0,0,0, 1,0,0,1,0);
    add(0,1,0,0,3,1,0,0,0,0, 0,1,0,1,0);
    add(0,1,0,0,0,0,3,1,0,0, 0,1,0,1,0);
    add(0,0,3,1,0,0,0,0,0,0, 0,0,0,1,0);
    add(0,0,0,0,0,0,0,0,0,0, 0,0,0,0,1);
    add(0,1,0,0,0,0,3,0,1,0, 1,0,0,0,0);
    for (int i = 0; i < 4; i++) add(0,1,3,1,0,0,9,0,1,0, 0,1,0,1,0);
    add(0,1,3,1,0,0,9,0,1,0, 1,0,0,0,1);
    add(0,1,3,1,0,0,0,0,0,0, 1,0,0,1,0);
    for (int i = 0; i < 3; i++) add(0,0,0,0,0,0,0,0,0,0, 0,0,0,1,0);
    add(0,0,0,0,0,0,0,0,0,0, 0,0,0,0,1);
    add(0,1,0,0,0,0,0,0,0,1, 1,0,0,0,0);
    for (int i = 0; i < 2; i++) add(0,1,0,0,0,0,0,0,0,0, 0,1,1,0,0);
    add(0,1,0,0,0,0,0,0,0,0, 1,0,0,0,0);
    add(0,1,0,0,0,0,5,1,1,1, 1,0,0,0,0);
    for (int i = 0; i < 2; i++) add(0,1,0,0,0,0,0,0,0,0, 0,1,1,1,0);
    add(0,1,5,1,0,0,0,0,0,0, 0,1,0,1,0);
    add(0,1,0,0,0,0,0,0,0,0, 1,0,0,1,0);
    add(0,0,0,0,0,0,0,0,0,0, 0,0,0,0,1);
    add(0,1,0,0,0,0,6,1,1,0, 1,0,0,0,0);
    add(0,0,0,0,0,0,0,0,0,0, 0,0,0,1,0);
    add(1,1,0,0,0,0,0,0,0,0, 1,0,0,1,0);
    for (int i = 0; i < 4; i++) add(0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0);

    repeat (2) @(posedge clk);
    #1;
    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].valid, tbl[i].r1, tbl[i].r1re, tbl[i].r2, tbl[i].r2re,
            tbl[i].w, tbl[i].we, tbl[i].multi, tbl[i].ctrl);
      @(negedge clk);
      chk($sformatf("tbl%0d_fire", i), 32'(issue_fire), 32'(tbl[i].fire));
      chk($sformatf("tbl%0d_stall", i), 32'(id_stall), 32'(tbl[i].stall));
      chk($sformatf("tbl%0d_flush", i), 32'(flush), 32'(tbl[i].flsh));
      chk($sformatf("tbl%0d_busy", i), 32'(busy), 32'(tbl[i].bsy));
      chk($sformatf("tbl%0d_done", i), 32'(ecc_done), 32'(tbl[i].done));
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    chk("rst_issue_cnt", 32'(issue_cnt), 32'd0);
    chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);
    chk("rst_ecc_wsel", 32'(ecc_wsel), 32'd0);
    chk("rst_ecc_we", 32'(ecc_we), 32'd0);

    // Randomized run, model starts from a reset edge.
    @(posedge clk);
    #1;
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    model_reset();
    t = 0;
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) != 0),
            5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0));
      model_cycle();
      @(posedge clk);
      #1;
    end

    // Saturation run: a 15-cycle ECC op re-issued back to back stalls 15 of every 16 cycles.
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    rst = 0;
    s_valid = 1;
    s_iss = 0; s_stl = 0; s_end = 0;
    for (int i = 0; i < 70000; i++) begin
      if (i < s_end) begin
        if (s_stl < 65535) s_stl++;
      end else begin
        if (s_iss < 65535) s_iss++;
        s_end = i + 16;
      end
      @(posedge clk);
      #1;
    end
    s_valid = 0;
    @(negedge clk);
    chk("sat_stall_cnt", 32'(s_stall_cnt), 32'(s_stl));
    chk("sat_stall_max", 32'(s_stall_cnt), 32'hFFFF);
    chk("sat_issue_cnt", 32'(s_issue_cnt), 32'(s_iss));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
